// File: rtl/usb_dev_rw_if.sv
// Protocol-layer and memory-side signal bundle for usb_dev_rw.
// slave: the responder itself; master: the protocol layer / memory around it.
interface usb_dev_rw_if;
    logic [18:0] token_in;
    logic        token_valid;
    logic [71:0] data_in;
    logic        data_valid;
    logic        data_crc_ok;
    logic        host_ack;
    logic        host_nak;
    logic [7:0]  hs_pid;
    logic        hs_valid;
    logic [71:0] data_out;
    logic        data_out_vld;
    logic        data_out_rdy;
    logic [15:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [63:0] mem_rdata;
    logic        mem_rvalid;

    modport slave (
        input  token_in, token_valid, data_in, data_valid, data_crc_ok,
        input  host_ack, host_nak, data_out_rdy, mem_rdata, mem_rvalid,
        output hs_pid, hs_valid, data_out, data_out_vld,
        output mem_addr, mem_wdata, mem_we, mem_re
    );

    modport master (
        output token_in, token_valid, data_in, data_valid, data_crc_ok,
        output host_ack, host_nak, data_out_rdy, mem_rdata, mem_rvalid,
        input  hs_pid, hs_valid, data_out, data_out_vld,
        input  mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/usb_dev_rw.sv
// Device-side responder for the two-phase (mempage, then data) USB read/write
// transfer onto a 64-bit memory. All outputs are registered.
module usb_dev_rw #(
    parameter logic [6:0]  DEV_ADDR = 7'b1010000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst_b,
    usb_dev_rw_if.slave bus
);

    localparam logic [7:0]  PID_OUT  = 8'b11100001;
    localparam logic [7:0]  PID_IN   = 8'b01101001;
    localparam logic [7:0]  PID_DATA = 8'b11000011;
    localparam logic [7:0]  PID_ACK  = 8'b11010010;
    localparam logic [7:0]  PID_NAK  = 8'b01011010;
    localparam logic [3:0]  ENDP4    = 4'b0010;
    localparam logic [3:0]  ENDP8    = 4'b0001;
    localparam int unsigned TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR_DATA, S_WR_DATA, S_RD_REQ, S_RD_WAIT, S_RD_SEND, S_HS_WAIT
    } state_t;

    function automatic logic [63:0] rev64(input logic [63:0] x);
        logic [63:0] r;
        for (int unsigned i = 0; i < 64; i++) begin
            r[i] = x[63 - i];
        end
        return r;
    endfunction

    state_t        state_q, state_d;
    logic          addr_valid_q, addr_valid_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    hs_pid_q, hs_pid_d;
    logic          hs_valid_q, hs_valid_d;
    logic [71:0]   data_out_q, data_out_d;
    logic          data_out_vld_q, data_out_vld_d;
    logic [15:0]   mem_addr_q, mem_addr_d;
    logic [63:0]   mem_wdata_q, mem_wdata_d;
    logic          mem_we_q, mem_we_d;
    logic          mem_re_q, mem_re_d;

    logic [7:0]  tok_pid;
    logic [6:0]  tok_addr;
    logic [3:0]  tok_endp;
    logic        tok_here;
    logic [63:0] rx_word;
    logic        rx_good;
    logic        timed_out;

    assign tok_pid   = bus.token_in[18:11];
    assign tok_addr  = bus.token_in[10:4];
    assign tok_endp  = bus.token_in[3:0];
    assign tok_here  = bus.token_valid && (tok_addr == DEV_ADDR);
    assign rx_word   = rev64(bus.data_in[63:0]);
    assign rx_good   = bus.data_crc_ok && (bus.data_in[71:64] == PID_DATA);
    assign timed_out = (timer_q == TW'(TIMEOUT));

    always_comb begin
        state_d        = state_q;
        addr_valid_d   = addr_valid_q;
        timer_d        = timer_q;
        hs_pid_d       = hs_pid_q;
        hs_valid_d     = 1'b0;
        data_out_d     = data_out_q;
        data_out_vld_d = data_out_vld_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_we_d       = 1'b0;
        mem_re_d       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (tok_here) begin
                    if (tok_pid == PID_OUT && tok_endp == ENDP4) begin
                        timer_d = '0;
                        state_d = addr_valid_q ? S_WR_DATA : S_ADDR_DATA;
                    end else if (tok_pid == PID_IN && tok_endp == ENDP8 && addr_valid_q) begin
                        mem_re_d = 1'b1;
                        state_d  = S_RD_REQ;
                    end else begin
                        hs_valid_d = 1'b1;
                        hs_pid_d   = PID_NAK;
                    end
                end
            end
            // An arriving packet wins over a timeout landing in the same cycle.
            S_ADDR_DATA, S_WR_DATA: begin
                if (bus.data_valid) begin
                    hs_valid_d = 1'b1;
                    state_d    = S_IDLE;
                    if (rx_good) begin
                        hs_pid_d = PID_ACK;
                        if (state_q == S_ADDR_DATA) begin
                            mem_addr_d   = rx_word[15:0];
                            addr_valid_d = 1'b1;
                        end else begin
                            mem_we_d     = 1'b1;
                            mem_wdata_d  = rx_word;
                            addr_valid_d = 1'b0;
                        end
                    end else begin
                        hs_pid_d = PID_NAK;
                    end
                end else if (timed_out) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RD_REQ: begin
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (bus.mem_rvalid) begin
                    data_out_d     = {PID_DATA, rev64(bus.mem_rdata)};
                    data_out_vld_d = 1'b1;
                    state_d        = S_RD_SEND;
                end
            end
            S_RD_SEND: begin
                if (bus.data_out_rdy) begin
                    data_out_vld_d = 1'b0;
                    timer_d        = '0;
                    state_d        = S_HS_WAIT;
                end
            end
            S_HS_WAIT: begin
                if (bus.host_nak) begin
                    data_out_vld_d = 1'b1;
                    state_d        = S_RD_SEND;
                end else if (bus.host_ack) begin
                    addr_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end else if (timed_out) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q        <= S_IDLE;
            addr_valid_q   <= 1'b0;
            timer_q        <= '0;
            hs_pid_q       <= '0;
            hs_valid_q     <= 1'b0;
            data_out_q     <= '0;
            data_out_vld_q <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_we_q       <= 1'b0;
            mem_re_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_valid_q   <= addr_valid_d;
            timer_q        <= timer_d;
            hs_pid_q       <= hs_pid_d;
            hs_valid_q     <= hs_valid_d;
            data_out_q     <= data_out_d;
            data_out_vld_q <= data_out_vld_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_we_q       <= mem_we_d;
            mem_re_q       <= mem_re_d;
        end
    end

    assign bus.hs_pid       = hs_pid_q;
    assign bus.hs_valid     = hs_valid_q;
    assign bus.data_out     = data_out_q;
    assign bus.data_out_vld = data_out_vld_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_re       = mem_re_q;

endmodule

// File: tb/tb_usb_dev_rw.sv
// Directed bench for usb_dev_rw: packet vector table plus hand-written read,
// timeout and reset sequences.
module tb_usb_dev_rw;

    localparam logic [6:0] DEV  = 7'b1010000;
    localparam logic [7:0] OUTP = 8'b11100001;
    localparam logic [7:0] INP  = 8'b01101001;
    localparam logic [7:0] DAT  = 8'b11000011;
    localparam logic [7:0] ACK  = 8'b11010010;
    localparam logic [7:0] NAK  = 8'b01011010;
    localparam logic [3:0] E4   = 4'b0010;
    localparam logic [3:0] E8   = 4'b0001;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   re_cnt = 0;
    int   hs_cnt = 0;

    usb_dev_rw_if bus();

    usb_dev_rw #(.DEV_ADDR(DEV), .TIMEOUT(255)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_re === 1'b1)   re_cnt <= re_cnt + 1;
        if (bus.hs_valid === 1'b1) hs_cnt <= hs_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    typedef struct {
        bit          is_tok;
        logic [7:0]  pid;
        logic [6:0]  addr;
        logic [3:0]  endp;
        logic [63:0] word;
        logic        crc_ok;
        int          exp_hs;   // 0 none, 1 ACK, 2 NAK
        logic        exp_we;
        logic [15:0] exp_addr;
        logic [63:0] exp_wdata;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [63:0] rev(input logic [63:0] x);
        logic [63:0] r;
        r = {<<{x}};
        return r;
    endfunction

    function automatic vec_t mk_tok(input logic [7:0] pid, input logic [6:0] addr,
                                    input logic [3:0] endp, input int hs);
        vec_t v;
        v = '{is_tok: 1'b1, pid: pid, addr: addr, endp: endp, word: '0, crc_ok: 1'b0,
              exp_hs: hs, exp_we: 1'b0, exp_addr: '0, exp_wdata: '0};
        return v;
    endfunction

    function automatic vec_t mk_dat(input logic [7:0] pid, input logic [63:0] word,
                                    input logic crc, input int hs, input logic we,
                                    input logic [15:0] a, input logic [63:0] wd);
        vec_t v;
        v = '{is_tok: 1'b0, pid: pid, addr: '0, endp: '0, word: word, crc_ok: crc,
              exp_hs: hs, exp_we: we, exp_addr: a, exp_wdata: wd};
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        if (v.is_tok) begin
            bus.token_in    = {v.pid, v.addr, v.endp};
            bus.token_valid = 1'b1;
        end else begin
            bus.data_in     = {v.pid, rev(v.word)};
            bus.data_crc_ok = v.crc_ok;
            bus.data_valid  = 1'b1;
        end
        tick();
        bus.token_valid = 1'b0;
        bus.data_valid  = 1'b0;
        bus.data_crc_ok = 1'b0;
        check($sformatf("v%0d_hs_valid", idx), bus.hs_valid, (v.exp_hs != 0));
        if (v.exp_hs != 0)
            check($sformatf("v%0d_hs_pid", idx), bus.hs_pid, (v.exp_hs == 1) ? ACK : NAK);
        check($sformatf("v%0d_mem_we", idx), bus.mem_we, v.exp_we);
        if (v.exp_we) begin
            check($sformatf("v%0d_mem_addr", idx), bus.mem_addr, v.exp_addr);
            check($sformatf("v%0d_mem_wdata", idx), bus.mem_wdata, v.exp_wdata);
        end
        tick();
        check($sformatf("v%0d_hs_strobe_end", idx), bus.hs_valid, 1'b0);
    endtask

    task automatic send_tok(input logic [7:0] pid, input logic [3:0] endp);
        bus.token_in    = {pid, DEV, endp};
        bus.token_valid = 1'b1;
        tick();
        bus.token_valid = 1'b0;
    endtask

    task automatic wait_vld(input string name);
        int n;
        n = 0;
        while (bus.data_out_vld !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        check(name, bus.data_out_vld, 1'b1);
    endtask

    task automatic rdy_pulse(input string name);
        bus.data_out_rdy = 1'b1;
        tick();
        bus.data_out_rdy = 1'b0;
        check(name, bus.data_out_vld, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hs_valid"}, bus.hs_valid, 1'b0);
        check({tag, "_hs_pid"}, bus.hs_pid, 8'h00);
        check({tag, "_data_out"}, bus.data_out, 72'h0);
        check({tag, "_data_out_vld"}, bus.data_out_vld, 1'b0);
        check({tag, "_mem_addr"}, bus.mem_addr, 16'h0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 64'h0);
        check({tag, "_mem_we"}, bus.mem_we, 1'b0);
        check({tag, "_mem_re"}, bus.mem_re, 1'b0);
    endtask

    initial begin
        logic [71:0] exp_do;
        int re0;
        int hs0;

        bus.token_in     = '0;
        bus.token_valid  = 1'b0;
        bus.data_in      = '0;
        bus.data_valid   = 1'b0;
        bus.data_crc_ok  = 1'b0;
        bus.host_ack     = 1'b0;
        bus.host_nak     = 1'b0;
        bus.data_out_rdy = 1'b0;
        bus.mem_rdata    = '0;
        bus.mem_rvalid   = 1'b0;

        repeat (3) tick();
        check_all_zero("reset");
        rst_b = 1'b1;
        tick();

        // Write, bad-CRC/bad-PID retries, foreign address and unsupported tokens.
        vecs.push_back(mk_tok(OUTP, DEV, E4, 0));
        vecs.push_back(mk_dat(DAT, 64'h40, 1'b1, 1, 1'b0, '0, '0));
        vecs.push_back(mk_tok(OUTP, DEV, E4, 0));
        vecs.push_back(mk_dat(DAT, 64'hDEADBEEF01234567, 1'b1, 1, 1'b1, 16'h0040, 64'hDEADBEEF01234567));
        vecs.push_back(mk_tok(OUTP, DEV, E4, 0));
        vecs.push_back(mk_dat(DAT, 64'h55, 1'b0, 2, 1'b0, '0, '0));
        vecs.push_back(mk_tok(INP, DEV, E8, 2));
        vecs.push_back(mk_tok(OUTP, DEV, E4, 0));
        vecs.push_back(mk_dat(DAT, 64'h55, 1'b1, 1, 1'b0, '0, '0));
        vecs.push_back(mk_tok(OUTP, DEV, E4, 0));
        vecs.push_back(mk_dat(8'h4B, 64'h99, 1'b1, 2, 1'b0, '0, '0));
        vecs.push_back(mk_tok(OUTP, DEV, E4, 0));
        vecs.push_back(mk_dat(DAT, 64'h1111, 1'b1, 1, 1'b1, 16'h0055, 64'h1111));
        vecs.push_back(mk_tok(INP, 7'h11, E8, 0));
        vecs.push_back(mk_tok(OUTP, 7'h11, E4, 0));
        vecs.push_back(mk_dat(DAT, 64'h77, 1'b1, 0, 1'b0, '0, '0));
        vecs.push_back(mk_tok(INP, DEV, E4, 2));
        vecs.push_back(mk_tok(OUTP, DEV, E8, 2));
        vecs.push_back(mk_tok(INP, DEV, E8, 2));

        foreach (vecs[i]) apply(vecs[i], i);
        check("no_mem_re_in_table", re_cnt, 0);

        // Read: mempage, IN token, delayed memory return, NAK resend, ack.
        re0 = re_cnt;
        apply(mk_tok(OUTP, DEV, E4, 0), 100);
        apply(mk_dat(DAT, 64'h40, 1'b1, 1, 1'b0, '0, '0), 101);
        send_tok(INP, E8);
        check("rd_mem_re", bus.mem_re, 1'b1);
        check("rd_mem_addr", bus.mem_addr, 16'h0040);
        tick();
        check("rd_mem_re_pulse", bus.mem_re, 1'b0);
        repeat (2) tick();
        check("rd_wait_no_vld", bus.data_out_vld, 1'b0);
        bus.mem_rdata  = 64'hCAFE;
        bus.mem_rvalid = 1'b1;
        tick();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        wait_vld("rd_vld");
        exp_do = {DAT, rev(64'hCAFE)};
        check("rd_data_out", bus.data_out, exp_do);
        hs0 = hs_cnt;
        send_tok(INP, E8);
        tick();
        check("rd_busy_token_ignored", hs_cnt, hs0);
        check("rd_vld_held", bus.data_out_vld, 1'b1);
        rdy_pulse("rd_vld_drop");
        bus.host_nak = 1'b1;
        tick();
        bus.host_nak = 1'b0;
        wait_vld("nak_resend_vld");
        check("nak_resend_data", bus.data_out, exp_do);
        check("nak_no_reread", re_cnt - re0, 1);
        rdy_pulse("nak_vld_drop");
        bus.host_ack = 1'b1;
        bus.host_nak = 1'b1;
        tick();
        bus.host_ack = 1'b0;
        bus.host_nak = 1'b0;
        wait_vld("acknak_resend_vld");
        check("acknak_resend_data", bus.data_out, exp_do);
        rdy_pulse("acknak_vld_drop");
        bus.host_ack = 1'b1;
        tick();
        bus.host_ack = 1'b0;
        tick();
        check("ack_vld_low", bus.data_out_vld, 1'b0);
        apply(mk_tok(INP, DEV, E8, 2), 102);
        check("read_mem_re_count", re_cnt - re0, 1);

        // Timeout waiting for the mempage packet.
        hs0 = hs_cnt;
        apply(mk_tok(OUTP, DEV, E4, 0), 200);
        repeat (300) tick();
        check("timeout_no_hs", hs_cnt, hs0);
        apply(mk_dat(DAT, 64'h77, 1'b1, 0, 1'b0, '0, '0), 201);
        apply(mk_tok(INP, DEV, E8, 2), 202);

        // Reset while waiting on memory read data.
        apply(mk_tok(OUTP, DEV, E4, 0), 300);
        apply(mk_dat(DAT, 64'h40, 1'b1, 1, 1'b0, '0, '0), 301);
        send_tok(INP, E8);
        tick();
        rst_b = 1'b0;
        #1;
        check_all_zero("rst_rd_wait");
        tick();
        rst_b = 1'b1;
        tick();
        bus.mem_rdata  = 64'hBEEF;
        bus.mem_rvalid = 1'b1;
        tick();
        bus.mem_rvalid = 1'b0;
        tick();
        check("rst_abandon_no_vld", bus.data_out_vld, 1'b0);
        apply(mk_tok(INP, DEV, E8, 2), 302);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
